// File: rtl/bit_deser.sv
// Serial-to-parallel deserializer: hunts for a start bit (1), collects WIDTH data
// bits, checks the stop bit (0) and hands the word to a ready/valid output register.
module bit_deser #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] word_out,
    output logic             word_vld,
    output logic             frm_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q,   state_d;
    logic [CW-1:0]    cnt_q,     cnt_d;
    logic [WIDTH-1:0] shift_q,   shift_d;
    logic [WIDTH-1:0] word_q,    word_d;
    logic             vld_q,     vld_d;
    logic             frm_err_q, frm_err_d;
    logic             overrun_q, overrun_d;

    // State, data path and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            cnt_q     <= {CW{1'b0}};
            shift_q   <= {WIDTH{1'b0}};
            word_q    <= {WIDTH{1'b0}};
            vld_q     <= 1'b0;
            frm_err_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            vld_q     <= vld_d;
            frm_err_q <= frm_err_d;
            overrun_q <= overrun_d;
        end
    end

    // Next-state: framing FSM, shifting, output handshake and error flags
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        word_d    = word_q;
        frm_err_d = 1'b0;
        overrun_d = overrun_q;

        // A consuming edge empties the output unless a good frame reloads it below
        if (vld_q && out_rdy) begin
            vld_d = 1'b0;
        end else begin
            vld_d = vld_q;
        end

        if (bit_vld) begin
            case (state_q)
                HUNT: begin
                    if (bit_in) begin
                        state_d = DATA;
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        state_d = HUNT;
                    end
                end
                DATA: begin
                    if (MSB_FIRST != 0) begin
                        shift_d = {shift_q[WIDTH-2:0], bit_in};
                    end else begin
                        shift_d = {bit_in, shift_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end
                STOP: begin
                    state_d = HUNT;
                    if (bit_in) begin
                        frm_err_d = 1'b1;
                    end else if (!vld_q || out_rdy) begin
                        word_d = shift_q;
                        vld_d  = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    cnt_d   = {CW{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    assign word_out = word_q;
    assign word_vld = vld_q;
    assign frm_err  = frm_err_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_bit_deser.sv
// Directed self-checking bench for bit_deser: one MSB-first and one LSB-first
// instance share the same serial stimulus.
module tb_bit_deser;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_vld;
    logic       out_rdy;
    logic [7:0] word_out_m;
    logic       word_vld_m;
    logic       frm_err_m;
    logic       overrun_m;
    logic [7:0] word_out_l;
    logic       word_vld_l;
    logic       frm_err_l;
    logic       overrun_l;

    int n_checks;
    int n_fail;

    bit_deser #(.WIDTH(8), .MSB_FIRST(1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_in   (bit_in),
        .bit_vld  (bit_vld),
        .out_rdy  (out_rdy),
        .word_out (word_out_m),
        .word_vld (word_vld_m),
        .frm_err  (frm_err_m),
        .overrun  (overrun_m)
    );

    bit_deser #(.WIDTH(8), .MSB_FIRST(0)) u_dut_lsb (
        .clk      (clk),
        .rst_n    (rst_n),
        .bit_in   (bit_in),
        .bit_vld  (bit_vld),
        .out_rdy  (out_rdy),
        .word_out (word_out_l),
        .word_vld (word_vld_l),
        .frm_err  (frm_err_l),
        .overrun  (overrun_l)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic v);
        @(negedge clk);
        bit_in  = b;
        bit_vld = v;
    endtask

    // Start bit plus eight data bits, sent left to right; optional idle gaps
    task automatic send_frame(input logic [7:0] data, input logic gaps);
        send_bit(1'b1, 1'b1);
        if (gaps) send_bit(1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            send_bit(data[i], 1'b1);
            if (gaps) send_bit(~data[i], 1'b0);
        end
    endtask

    task automatic send_stop(input logic b, input logic rdy);
        @(negedge clk);
        bit_in  = b;
        bit_vld = 1'b1;
        out_rdy = rdy;
    endtask

    task automatic idle();
        @(negedge clk);
        bit_in  = 1'b0;
        bit_vld = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bit_in   = 1'b0;
        bit_vld  = 1'b0;
        out_rdy  = 1'b1;

        // Reset state
        idle();
        idle();
        check_eq("rst_word", {8'h00, word_out_m}, 16'h0000);
        check_eq("rst_vld",  {15'h0, word_vld_m}, 16'h0000);
        check_eq("rst_err",  {15'h0, frm_err_m},  16'h0000);
        check_eq("rst_ovr",  {15'h0, overrun_m},  16'h0000);
        rst_n = 1'b1;

        // Continuous frame A5, both bit orders
        send_frame(8'hA5, 1'b0);
        check_eq("a5_pre_vld", {15'h0, word_vld_m}, 16'h0000);
        send_stop(1'b0, 1'b1);
        idle();
        check_eq("a5_vld",   {15'h0, word_vld_m}, 16'h0001);
        check_eq("a5_word",  {8'h00, word_out_m}, 16'h00A5);
        check_eq("a5_lsb",   {8'h00, word_out_l}, 16'h00A5);
        check_eq("a5_err",   {15'h0, frm_err_m},  16'h0000);
        check_eq("a5_ovr",   {15'h0, overrun_m},  16'h0000);
        idle();
        check_eq("a5_drain", {15'h0, word_vld_m}, 16'h0000);

        // Frame 01: LSB-first instance reverses it
        send_frame(8'h01, 1'b0);
        send_stop(1'b0, 1'b1);
        idle();
        check_eq("x01_msb", {8'h00, word_out_m}, 16'h0001);
        check_eq("x01_lsb", {8'h00, word_out_l}, 16'h0080);
        check_eq("x01_lvld", {15'h0, word_vld_l}, 16'h0001);

        // Bad stop bit, then a good frame
        send_frame(8'h33, 1'b0);
        send_stop(1'b1, 1'b1);
        idle();
        check_eq("err_pulse", {15'h0, frm_err_m},  16'h0001);
        check_eq("err_vld",   {15'h0, word_vld_m}, 16'h0000);
        check_eq("err_word",  {8'h00, word_out_m}, 16'h0001);
        idle();
        check_eq("err_clear", {15'h0, frm_err_m},  16'h0000);
        send_frame(8'h0F, 1'b0);
        send_stop(1'b0, 1'b1);
        idle();
        check_eq("x0f_word", {8'h00, word_out_m}, 16'h000F);
        check_eq("x0f_vld",  {15'h0, word_vld_m}, 16'h0001);

        // Backpressure: second word dropped, overrun sticky
        idle();
        out_rdy = 1'b0;
        send_frame(8'h11, 1'b0);
        send_stop(1'b0, 1'b0);
        idle();
        check_eq("x11_word", {8'h00, word_out_m}, 16'h0011);
        check_eq("x11_ovr",  {15'h0, overrun_m},  16'h0000);
        send_frame(8'h22, 1'b0);
        send_stop(1'b0, 1'b0);
        idle();
        check_eq("ovr_word", {8'h00, word_out_m}, 16'h0011);
        check_eq("ovr_vld",  {15'h0, word_vld_m}, 16'h0001);
        check_eq("ovr_set",  {15'h0, overrun_m},  16'h0001);
        out_rdy = 1'b1;
        idle();
        check_eq("ovr_drain", {15'h0, word_vld_m}, 16'h0000);
        check_eq("ovr_stick", {15'h0, overrun_m},  16'h0001);

        // Reset after four data bits clears everything asynchronously
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        @(negedge clk);
        bit_vld = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_eq("mid_word", {8'h00, word_out_m}, 16'h0000);
        check_eq("mid_ovr",  {15'h0, overrun_m},  16'h0000);
        check_eq("mid_vld",  {15'h0, word_vld_m}, 16'h0000);
        idle();
        rst_n = 1'b1;
        send_frame(8'hC3, 1'b0);
        send_stop(1'b0, 1'b1);
        idle();
        check_eq("xc3_word", {8'h00, word_out_m}, 16'h00C3);
        check_eq("xc3_vld",  {15'h0, word_vld_m}, 16'h0001);

        // Consume and good stop on the same edge: reload without overrun
        idle();
        out_rdy = 1'b0;
        send_frame(8'h5A, 1'b0);
        send_stop(1'b0, 1'b0);
        send_frame(8'h96, 1'b0);
        check_eq("sim_hold", {8'h00, word_out_m}, 16'h005A);
        send_stop(1'b0, 1'b1);
        idle();
        check_eq("sim_word", {8'h00, word_out_m}, 16'h0096);
        check_eq("sim_vld",  {15'h0, word_vld_m}, 16'h0001);
        check_eq("sim_ovr",  {15'h0, overrun_m},  16'h0000);

        // Gapped bit_vld during frame 3C
        idle();
        send_frame(8'h3C, 1'b1);
        send_stop(1'b0, 1'b1);
        idle();
        check_eq("gap_word", {8'h00, word_out_m}, 16'h003C);
        check_eq("gap_vld",  {15'h0, word_vld_m}, 16'h0001);
        check_eq("gap_err",  {15'h0, frm_err_m},  16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bit_deser.md
BIT_DESER -- requirements
Module: bit_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame (legal range 2..16).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = first data bit lands in word_out[WIDTH-1]; 0 = first data bit lands in word_out[0].
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port bit_in  input  1  serial data bit from the upstream mux flop q.
REQ-006 SHALL have port bit_vld  input  1  bit_in is sampled only at edges where bit_vld=1.
REQ-007 SHALL have port out_rdy  input  1  downstream accepts word_out at edges where word_vld=1 and out_rdy=1.
REQ-008 SHALL have port word_out  output  WIDTH  assembled data word.
REQ-009 SHALL have port word_vld  output  1  word_out holds an unconsumed word.
REQ-010 SHALL have port frm_err  output  1  one-cycle pulse: stop bit was not 0.
REQ-011 SHALL have port overrun  output  1  sticky: a completed word was dropped because the output was still full.

Function
REQ-012 SHALL frame data as: start bit 1, then WIDTH data bits, then stop bit 0; only edges with bit_vld=1 count.
REQ-013 SHALL implement FSM states HUNT, DATA, STOP.
REQ-014 HUNT: accepted bit 1 -> DATA with bit counter cleared; accepted bit 0 -> stay in HUNT.
REQ-015 DATA: each accepted bit shifts into the shift register and increments the counter; the WIDTH-th accepted bit -> STOP.
REQ-016 Counter width SHALL be clog2(WIDTH+1); the counter SHALL never wrap within a frame.
REQ-017 STOP, accepted bit 0: frame good; the shift register is transferred to the output register if the output is empty or draining; FSM -> HUNT.
REQ-018 STOP, accepted bit 1: frm_err=1 for exactly the next cycle; word discarded; output register untouched; FSM -> HUNT (that 1 is not reused as a start bit).
REQ-019 bit_vld=0 SHALL freeze the FSM, counter and shift register for that edge.
REQ-020 Latency: stop bit accepted at edge N -> word_vld=1 and word_out valid from edge N (first visible in cycle N+1).
REQ-021 word_vld and word_out SHALL stay stable until a consuming edge (word_vld=1, out_rdy=1); at that edge word_vld clears unless a new word loads at the same edge.
REQ-022 Simultaneous consume and good stop bit at the same edge: the new word loads, word_vld stays 1, and overrun is not set.
REQ-023 Good stop bit while word_vld=1 and out_rdy=0: the new word is dropped, the held word is kept, and overrun is set to 1; overrun stays 1 until reset.
REQ-024 The shift register SHALL not affect word_out until transfer; output register bits SHALL be registered, with no combinational path from bit_in.
REQ-025 frm_err and overrun SHALL be registered outputs.

Reset
REQ-026 While rst_n=0, asynchronously: FSM=HUNT, counter=0, shift register=0, word_out=0, word_vld=0, frm_err=0, overrun=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release the block hunts for a new start bit.
REQ-028 The first accepted bit SHALL be sampled at the first posedge after rst_n deasserts.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1, out_rdy=1, bit_vld=1 continuous, bits 1,1010_0101,0 -> word_vld=1 for one cycle with word_out=8'hA5; frm_err=0; overrun=0.
REQ-030 MSB_FIRST=0, same bit stream -> word_out=8'hA5 bit-reversed, i.e. 8'hA5 (palindromic check) and then 1,0000_0001,0 -> word_out=8'h80.
REQ-031 Bits 1,0011_0011,1 -> frm_err pulses for 1 cycle, word_vld remains 0; the following frame 1,0000_1111,0 -> word_out=8'h0F.
REQ-032 out_rdy=0, two good frames 8'h11 then 8'h22 -> word_out holds 8'h11, overrun=1; raising out_rdy consumes 8'h11 and word_vld then drops to 0.
REQ-033 bit_vld toggled 1/0 every cycle during frame 8'h3C -> same result as continuous (word_out=8'h3C), with latency stretched accordingly.
REQ-034 rst_n pulsed low after 4 data bits -> all outputs 0 immediately; the next full frame 8'hC3 decodes correctly.
